seq_shift_add_multiplier: RTL

//   Parametrised multi-cycle shift-and-add multiplier for the datapath.

---
 rtl/seq_shift_add_multiplier_if.sv | 22 ++
 rtl/seq_shift_add_multiplier.sv | 125 ++++++++++++
 2 files changed

// File: rtl/seq_shift_add_multiplier_if.sv
// Start/busy/done handshake bundle between the controller and the shift-add multiplier.
interface seq_shift_add_multiplier_if #(
    parameter int unsigned WIDTH = 32
);
    logic                   start;
    logic                   is_signed;
    logic [WIDTH-1:0]       dataA;
    logic [WIDTH-1:0]       dataB;
    logic                   busy;
    logic                   done;
    logic [2*WIDTH-1:0]     dataOut;

    modport master (
        output start, is_signed, dataA, dataB,
        input  busy, done, dataOut
    );

    modport slave (
        input  start, is_signed, dataA, dataB,
        output busy, done, dataOut
    );
endinterface

// File: rtl/seq_shift_add_multiplier.sv
// Multi-cycle shift-and-add multiplier: one multiplier bit per clock, full 2*WIDTH-bit
// signed or unsigned product, start/busy/done handshake.
module seq_shift_add_multiplier #(
    parameter int unsigned WIDTH = 32
) (
    input  logic                        clk,
    input  logic                        reset,
    seq_shift_add_multiplier_if.slave   bus
);
    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    state_e                 state_q, state_d;
    logic [2*WIDTH-1:0]     mcnd_q, mcnd_d;
    logic [WIDTH-1:0]       mpy_q, mpy_d;
    logic [2*WIDTH-1:0]     prod_q, prod_d;
    logic [CW-1:0]          count_q, count_d;
    logic                   neg_q, neg_d;
    logic [2*WIDTH-1:0]     dout_q, dout_d;

    logic                   accept;
    logic                   finish;
    logic [WIDTH-1:0]       mag_a;
    logic [WIDTH-1:0]       mag_b;
    logic [2*WIDTH-1:0]     prod_next;

    // Magnitudes kept unsigned so |-2^(WIDTH-1)| still fits in WIDTH bits.
    always_comb begin
        mag_a = bus.dataA;
        mag_b = bus.dataB;
        if (bus.is_signed && bus.dataA[WIDTH-1]) begin
            mag_a = ~bus.dataA + WIDTH'(1);
        end
        if (bus.is_signed && bus.dataB[WIDTH-1]) begin
            mag_b = ~bus.dataB + WIDTH'(1);
        end
    end

    assign prod_next = mpy_q[0] ? (prod_q + mcnd_q) : prod_q;

    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        finish   = 1'b0;
        bus.busy = 1'b0;
        bus.done = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = RUN;
                    accept  = 1'b1;
                end
            end
            RUN: begin
                bus.busy = 1'b1;
                if (count_q == LAST) begin
                    state_d = DONE;
                    finish  = 1'b1;
                end
            end
            DONE: begin
                bus.done = 1'b1;
                if (bus.start) begin
                    state_d = RUN;
                    accept  = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mcnd_d  = mcnd_q;
        mpy_d   = mpy_q;
        prod_d  = prod_q;
        count_d = count_q;
        neg_d   = neg_q;
        dout_d  = dout_q;
        if (accept) begin
            mcnd_d  = {{WIDTH{1'b0}}, mag_a};
            mpy_d   = mag_b;
            prod_d  = '0;
            count_d = '0;
            neg_d   = bus.is_signed & (bus.dataA[WIDTH-1] ^ bus.dataB[WIDTH-1]);
        end else if (state_q == RUN) begin
            prod_d  = prod_next;
            mcnd_d  = mcnd_q << 1;
            mpy_d   = mpy_q >> 1;
            count_d = count_q + CW'(1);
            if (finish) begin
                dout_d = neg_q ? (~prod_next + (2*WIDTH)'(1)) : prod_next;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            mcnd_q  <= '0;
            mpy_q   <= '0;
            prod_q  <= '0;
            count_q <= '0;
            neg_q   <= 1'b0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            mcnd_q  <= mcnd_d;
            mpy_q   <= mpy_d;
            prod_q  <= prod_d;
            count_q <= count_d;
            neg_q   <= neg_d;
            dout_q  <= dout_d;
        end
    end

    assign bus.dataOut = dout_q;
endmodule
